// File: rtl/sm_bcd_pkg.sv
// Shared types and constants for the sign-magnitude product BCD converter.
// Holds the FSM state enum, digit constants and elaboration-time sizing helpers.
package sm_bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int BCD_DIGIT_W = 4;
   localparam int ADD3_THRESH = 5;
   localparam int ADD3_VAL    = 3;

   // Enough bits to hold the shift count MAG_W down to zero.
   function automatic int cnt_width(input int mag_w);
      return (mag_w < 1) ? 1 : $clog2(mag_w + 1);
   endfunction

   function automatic longint unsigned pow10(input int n);
      longint unsigned r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: adds 3 when the digit is 5 or more.
// Purely combinational, no latency, no flow control.
module bcd_add3_digit
   import sm_bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] dig_i,
   output logic [BCD_DIGIT_W-1:0] dig_o
);

   assign dig_o = (dig_i >= BCD_DIGIT_W'(ADD3_THRESH)) ? dig_i + BCD_DIGIT_W'(ADD3_VAL) : dig_i;

endmodule

// File: rtl/sm_product_bcd_conv.sv
// Sequential double-dabble converter for the signed multiplier product, one bit per clock.
// Optional SM_BCD_NEG_ZERO_CLEAR_EN suppresses a negative sign on a zero magnitude.
module sm_product_bcd_conv
   import sm_bcd_pkg::*;
#(
   parameter int MAG_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          sign_in,
   input  logic [MAG_W-1:0]              mag_in,
   output logic                          busy,
   output logic                          done,
   output logic                          sign_out,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

   localparam int BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int SR_W  = BCD_W + MAG_W;
   localparam int CNT_W = cnt_width(MAG_W);

   if (MAG_W < 1 || pow10(DIGITS) <= ((64'd1 << MAG_W) - 64'd1)) begin : g_bad_cfg
      $fatal(1, "sm_product_bcd_conv: DIGITS too small for MAG_W, or MAG_W < 1");
   end

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [SR_W-1:0]    sr_q;
   logic [SR_W-1:0]    sr_d;
   logic [BCD_W-1:0]   dig_corr;
   logic               sign_lat_q;
   logic               sign_lat_d;
   logic               busy_q;
   logic               done_q;
   logic               sign_q;
   logic [BCD_W-1:0]   bcd_q;

   for (genvar i = 0; i < DIGITS; i++) begin : g_add3
      bcd_add3_digit u_add3 (
         .dig_i (sr_q[MAG_W + BCD_DIGIT_W*i +: BCD_DIGIT_W]),
         .dig_o (dig_corr[BCD_DIGIT_W*i +: BCD_DIGIT_W])
      );
   end

   // Correct every digit first, then shift the whole register left by one.
   assign sr_d = SR_W'({dig_corr, sr_q[MAG_W-1:0]} << 1);

`ifdef SM_BCD_NEG_ZERO_CLEAR_EN
   assign sign_lat_d = sign_in & (|mag_in);
`else
   assign sign_lat_d = sign_in;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sr_q       <= '0;
         sign_lat_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         sign_q     <= 1'b0;
         bcd_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  sign_lat_q <= sign_lat_d;
                  sr_q       <= {{BCD_W{1'b0}}, mag_in};
                  cnt_q      <= CNT_W'(MAG_W);
                  busy_q     <= 1'b1;
                  state_q    <= SHIFT;
               end
            end
            SHIFT: begin
               sr_q  <= sr_d;
               cnt_q <= cnt_q - 1'b1;
               // Last shift: publish the result on the same edge that enters DONE.
               if (cnt_q == CNT_W'(1)) begin
                  bcd_q   <= sr_d[SR_W-1 -: BCD_W];
                  sign_q  <= sign_lat_q;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sign_out = sign_q;
   assign bcd_out  = bcd_q;

endmodule
